// File: rtl/instr_assembler.sv
// Host-side instruction assembler: gathers a header beat plus eight 32-bit operand beats
// into a 267-bit instruction word and holds each issued word for HOLD_CYCLES clocks.
module instr_assembler #(
    parameter int HOST_W      = 32,
    parameter int DATA_W      = 256,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [HOST_W-1:0]   in_data,
    input  logic                in_sof,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                err_clr,
    output logic [DATA_W+10:0]  instruct,
    output logic                instr_valid,
    output logic                err
);

    localparam int BEATS = DATA_W / HOST_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam int HDR_W = 11;

    typedef enum logic [1:0] {
        S_HDR,
        S_DATA,
        S_HOLD
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   beat_cnt;
    logic [7:0]         hold_cnt;
    logic [HDR_W-1:0]   shadow_hdr;
    logic [DATA_W-1:0]  shadow_op;
    logic               accept;
    logic               last_beat;
    logic               err_set;

    assign in_ready  = (state != S_HOLD) && !reset;
    assign accept    = in_valid && in_ready;
    assign last_beat = accept && (state == S_DATA) && !in_sof
                       && (beat_cnt == CNT_W'(BEATS - 1));
    // Framing faults: stray operand beat while idle, or a new header cutting a word short.
    assign err_set   = accept && (((state == S_HDR) && !in_sof) || ((state == S_DATA) && in_sof));

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_HDR;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: next-state defaults to the current state first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_HDR:   if (accept && in_sof) state_nxt = S_DATA;
            S_DATA:  if (last_beat)        state_nxt = S_HOLD;
            S_HOLD:  if (hold_cnt <= 8'd1) state_nxt = S_HDR;
            default:                       state_nxt = S_HDR;
        endcase
    end

    // NOTE: the shadow word is cleared on reset so a fresh instruction never inherits stale operand bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            beat_cnt    <= '0;
            hold_cnt    <= '0;
            shadow_hdr  <= '0;
            shadow_op   <= '0;
            instruct    <= '0;
            instr_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            instr_valid <= 1'b0;

            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end

            // A header beat always restarts collection, whether idle or mid-word.
            if (accept && in_sof) begin
                shadow_hdr <= in_data[HDR_W-1:0];
                beat_cnt   <= '0;
            end else if (accept && (state == S_DATA)) begin
                shadow_op[int'(beat_cnt)*HOST_W +: HOST_W] <= in_data;
                beat_cnt <= beat_cnt + 1'b1;
            end

            // The final beat bypasses the shadow so the issued word includes it this edge.
            if (last_beat) begin
                instruct    <= {shadow_hdr, in_data, shadow_op[DATA_W-HOST_W-1:0]};
                instr_valid <= 1'b1;
                hold_cnt    <= 8'(HOLD_CYCLES);
            end else if (state == S_HOLD) begin
                hold_cnt <= hold_cnt - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_assembler.sv
// Randomized directed bench for instr_assembler; expected words come from a beat-level
// framing model (header + eight LS-first operand words) kept in this file.
module tb_instr_assembler;

    localparam int HOLD = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic [31:0]    in_data;
    logic           in_sof;
    logic           in_valid;
    logic           in_ready;
    logic           err_clr;
    logic [266:0]   instruct;
    logic           instr_valid;
    logic           err;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [10:0]    m_hdr;
    logic [31:0]    m_words [8];
    int             m_n;
    bit             m_in_frame;
    logic [266:0]   m_instr;
    bit             m_err;

    instr_assembler #(.HOST_W(32), .DATA_W(256), .HOLD_CYCLES(HOLD)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_data     (in_data),
        .in_sof      (in_sof),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .err_clr     (err_clr),
        .instruct    (instruct),
        .instr_valid (instr_valid),
        .err         (err)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [266:0] obs, input logic [266:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [266:0] assemble();
        logic [266:0] r;
        r = '0;
        r[266:256] = m_hdr;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = m_words[k];
        return r;
    endfunction

    task automatic model_reset();
        m_hdr      = '0;
        for (int k = 0; k < 8; k++) m_words[k] = '0;
        m_n        = 0;
        m_in_frame = 0;
        m_instr    = '0;
        m_err      = 0;
    endtask

    // Apply one accepted beat to the model; returns 1 when a word issues.
    task automatic model_beat(input logic [31:0] d, input bit sof, output bit issued);
        issued = 0;
        if (sof) begin
            if (m_in_frame) m_err = 1;
            m_hdr      = d[10:0];
            m_n        = 0;
            m_in_frame = 1;
        end else if (!m_in_frame) begin
            m_err = 1;
        end else begin
            m_words[m_n] = d;
            m_n++;
            if (m_n == 8) begin
                m_instr    = assemble();
                issued     = 1;
                m_in_frame = 0;
            end
        end
    endtask

    // Offer one beat after a random idle gap; called and returns at a falling edge.
    task automatic send(input logic [31:0] d, input bit sof, input bit measure);
        int gap;
        int budget;
        int low;
        bit acc;
        bit issued;
        gap = $urandom_range(0, 2);
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            in_sof   = 1'($urandom_range(0, 1));
            @(negedge clock);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        acc      = 0;
        budget   = 0;
        while (!acc && budget < 50) begin
            acc = in_ready;
            @(posedge clock);
            #1;
            if (!acc) begin
                check("stall_instruct_stable", instruct, m_instr);
                @(negedge clock);
            end
            budget++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            check("accept_timeout", 267'(acc), 267'(1));
            @(negedge clock);
            return;
        end
        model_beat(d, sof, issued);
        check("instr_valid", 267'(instr_valid), 267'(issued));
        check("instruct", instruct, m_instr);
        check("err", 267'(err), 267'(m_err));
        if (issued && measure) begin
            low = 0;
            while (in_ready === 1'b0 && low < 300) begin
                low++;
                @(posedge clock);
                #1;
                if (low == 1) check("instr_valid_pulse", 267'(instr_valid), 267'(0));
            end
            check("hold_len", 267'(low), 267'(HOLD));
        end
        @(negedge clock);
    endtask

    task automatic send_word(input logic [10:0] h, input logic [255:0] op, input bit measure);
        logic [31:0] hb;
        hb = $urandom;
        hb[10:0] = h;
        send(hb, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) send(op[32*k +: 32], 1'b0, (k == 7) ? measure : 1'b0);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(posedge clock);
        #1;
        m_err = 0;
        check("err_clr", 267'(err), 267'(0));
        @(negedge clock);
        err_clr = 1'b0;
    endtask

    task automatic pulse_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("ready_in_reset", 267'(in_ready), 267'(0));
        @(posedge clock);
        #1;
        check("reset_instruct", instruct, '0);
        check("reset_instr_valid", 267'(instr_valid), 267'(0));
        check("reset_err", 267'(err), 267'(0));
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        #1;
        check("ready_after_reset", 267'(in_ready), 267'(1));
        @(negedge clock);
    endtask

    initial begin
        logic [255:0] op;
        logic [10:0]  h;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_sof   = 1'b0;
        err_clr  = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        pulse_reset();

        // 1: single instruction, opcode 8 with enable, operand 12
        send_word(11'h018, 256'd12, 1'b1);
        check("t1_en", 267'(instruct[260]), 267'(1));
        check("t1_opcode", 267'(instruct[259:256]), 267'(8));
        check("t1_operand", 267'(instruct[255:0]), 267'(12));

        // 2: back-to-back, second header offered during HOLD
        send_word(11'h018, 256'd12, 1'b0);
        send_word(11'h01A, 256'd4, 1'b1);
        check("t2_opcode", 267'(instruct[259:256]), 267'(10));
        check("t2_operand", 267'(instruct[255:0]), 267'(4));

        // 3: operand words land least-significant first
        for (int k = 0; k < 8; k++) op[32*k +: 32] = 32'h1111_1111 * (k + 1);
        send_word(11'h009, op, 1'b1);
        check("t3_en", 267'(instruct[260]), 267'(0));
        check("t3_opcode", 267'(instruct[259:256]), 267'(9));
        check("t3_word0", 267'(instruct[31:0]), 267'(32'h1111_1111));
        check("t3_word7", 267'(instruct[255:224]), 267'(32'h8888_8888));

        // 4: stray operand beat while idle, then clear; then set and clear on the same edge
        send(32'h0000_0055, 1'b0, 1'b0);
        check("t4_err_set", 267'(err), 267'(1));
        clear_err();
        err_clr = 1'b1;
        send(32'h0000_0066, 1'b0, 1'b0);
        err_clr = 1'b0;
        check("t4_set_wins", 267'(err), 267'(1));
        clear_err();

        // 5: header after three operand beats aborts the partial word
        send(32'h0000_00F3, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) send($urandom, 1'b0, 1'b0);
        op = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        send_word(11'h027, op, 1'b1);
        check("t5_err", 267'(err), 267'(1));
        check("t5_operand", 267'(instruct[255:0]), 267'(op));
        clear_err();

        // 6: reset mid-collection, then a fresh instruction
        send(32'h0000_0013, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) send($urandom, 1'b0, 1'b0);
        pulse_reset();
        op = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        send_word(11'h01D, op, 1'b1);

        // Reset during HOLD releases in_ready immediately afterwards
        send_word(11'h011, op, 1'b0);
        pulse_reset();

        // Random instructions
        for (int i = 0; i < 6; i++) begin
            h  = 11'($urandom);
            op = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            send_word(h, op, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
